conv_sched: RTL

- Job sequencer for the multi-lane 3x3 convolution core (CORE_N parallel 3x3 multiply-add trees, fixed pipeline latency, no valid or enable of its own).
- For one feature-map job, walks the valid-convolution output grid in groups of CORE_N adjacent output columns and issues one group per cycle to the window loader and core.
- Regenerates valid and position tags aligned to the core's output.
- Throttles issue with a credit counter sized to the downstream result buffer, so the free-running core never overruns it.

---
 rtl/conv_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/conv_sched.sv
// conv_sched: job sequencer for the multi-lane 3x3 convolution core.
//
// Walks the valid-convolution output grid of one feature map (OW = cfg_w-2
// by OH = cfg_h-2) in row-major order, one group of CORE_N adjacent output
// columns per cycle. It issues each group to the window loader and core.
// A delay line of depth CORE_LAT regenerates valid and position tags that
// line up with the core's output. A credit counter sized to the downstream
// result buffer throttles issue so the free-running core never overruns it.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle job request (sampled only when idle)
//   cfg_w, cfg_h      input image width/height, captured on accepted start
//   hold              loader not ready; blocks issue this cycle
//   out_ack           downstream consumed one result group (returns a credit)
//   busy              job in progress (RUN or DRAIN)
//   done, err         one-cycle completion pulse; err marks an illegal config
//   iss_vld/row/col/mask  group issued this cycle and its position/lane mask
//   res_vld/row/col/mask  tags aligned to the core result, CORE_LAT later
module conv_sched #(
    parameter int CORE_N     = 4,
    parameter int CORE_LAT   = 4,
    parameter int DIM_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic              hold,
    input  logic              out_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              iss_vld,
    output logic [DIM_W-1:0]  iss_row,
    output logic [DIM_W-1:0]  iss_col,
    output logic [CORE_N-1:0] iss_mask,
    output logic              res_vld,
    output logic [DIM_W-1:0]  res_row,
    output logic [DIM_W-1:0]  res_col,
    output logic [CORE_N-1:0] res_mask
);

    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DIM_W-1:0]  ow, oh, row, col;
    logic [DIM_W-1:0]  last_row, last_col;
    logic [CORE_N-1:0] last_mask, mask;
    logic [CRD_W-1:0]  credits;
    logic              err_flag;
    logic              cfg_ok, issue, row_end, last_grp, pending;

    // Tag delay line; index CORE_LAT-1 is the stage aligned with the core output.
    logic [CORE_LAT-1:0] vld_p;
    logic [DIM_W-1:0]    row_p  [CORE_LAT];
    logic [DIM_W-1:0]    col_p  [CORE_LAT];
    logic [CORE_N-1:0]   mask_p [CORE_LAT];

    assign cfg_ok   = (cfg_w >= DIM_W'(3)) && (cfg_h >= DIM_W'(3));
    assign issue    = (state == S_RUN) && !hold && (credits != '0);
    assign row_end  = ({1'b0, col} + (DIM_W+1)'(CORE_N)) >= {1'b0, ow};
    assign last_grp = row_end && (row == oh - DIM_W'(1));
    // Entries still in flight after this edge, ignoring the one leaving now.
    assign pending  = (vld_p & ~(CORE_LAT'(1) << (CORE_LAT - 1))) != '0;

    always_comb begin
        mask = '0;
        for (int i = 0; i < CORE_N; i++)
            mask[i] = ({1'b0, col} + (DIM_W+1)'(i)) < {1'b0, ow};
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = cfg_ok ? S_RUN : S_DONE;
            S_RUN:   if (issue && last_grp) state_nxt = S_DRAIN;
            S_DRAIN: if (!pending) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy = (state == S_RUN) || (state == S_DRAIN);
        done = (state == S_DONE);
        err  = (state == S_DONE) && err_flag;
    end

    // Issue fields hold their last issued values while stalled.
    always_comb begin
        iss_vld  = issue;
        iss_row  = issue ? row  : last_row;
        iss_col  = issue ? col  : last_col;
        iss_mask = issue ? mask : last_mask;
    end

    // ---- Stage p0: job geometry and grid position ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ow       <= '0;
            oh       <= '0;
            row      <= '0;
            col      <= '0;
            err_flag <= 1'b0;
        end else if (state == S_IDLE && start) begin
            ow       <= cfg_w - DIM_W'(2);
            oh       <= cfg_h - DIM_W'(2);
            row      <= '0;
            col      <= '0;
            err_flag <= !cfg_ok;
        end else if (issue) begin
            if (row_end) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(CORE_N);
            end
        end
    end

    // Credits: issue and ack in the same cycle cancel; ack while full is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CRD_W'(FIFO_DEPTH);
        end else if (state == S_IDLE && start) begin
            credits <= CRD_W'(FIFO_DEPTH);
        end else if (issue && !out_ack) begin
            credits <= credits - CRD_W'(1);
        end else if (!issue && out_ack && credits < CRD_W'(FIFO_DEPTH)) begin
            credits <= credits + CRD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_row  <= '0;
            last_col  <= '0;
            last_mask <= '0;
        end else if (issue) begin
            last_row  <= row;
            last_col  <= col;
            last_mask <= mask;
        end
    end

    // ---- Stages p0..p(CORE_LAT-1): tag delay line matching core latency ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                row_p[i]  <= '0;
                col_p[i]  <= '0;
                mask_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= issue;
            row_p[0]  <= issue ? row  : '0;
            col_p[0]  <= issue ? col  : '0;
            mask_p[0] <= issue ? mask : '0;
            for (int i = 1; i < CORE_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                row_p[i]  <= row_p[i-1];
                col_p[i]  <= col_p[i-1];
                mask_p[i] <= mask_p[i-1];
            end
        end
    end

    assign res_vld  = vld_p[CORE_LAT-1];
    assign res_row  = row_p[CORE_LAT-1];
    assign res_col  = col_p[CORE_LAT-1];
    assign res_mask = mask_p[CORE_LAT-1];

endmodule
